// File: rtl/instr_mem_resp_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package instr_mem_resp_pkg;

    localparam int unsigned IMEM_DBITS = 32;
    localparam logic [IMEM_DBITS-1:0] IMEM_NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [IMEM_DBITS-1:0] instr;
        logic [IMEM_DBITS-1:0] pc;
        logic                  err;
    } imem_entry_t;

    // A PC is bad when it is not word aligned or addresses beyond the RAM.
    function automatic logic imem_pc_err(input logic [IMEM_DBITS-1:0] pc,
                                         input int unsigned addr_bits,
                                         input int unsigned dbits);
        logic [IMEM_DBITS-1:0] hi_s;
        if (addr_bits + 2 >= dbits) begin
            hi_s = '0;
        end else begin
            hi_s = pc >> (addr_bits + 2);
        end
        return (pc[1:0] != 2'b00) || (hi_s != '0);
    endfunction

endpackage

// File: rtl/instr_mem_resp_resp_fifo.sv
// Response buffer: DEPTH-entry circular FIFO with flush and occupancy count.
module instr_mem_resp_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_s;
    logic             pop_s;

    // Next-state pointers and count; flush voids any push or pop.
    always_comb begin
        push_s   = push_i && !flush_i;
        pop_s    = pop_i && !flush_i && (cnt_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder: accepts fetch PCs, reads the RAM and returns words in order.
// Define IMEM_PERF_EN to add the perf_req/perf_stall/perf_flush counters (DBITS must equal IMEM_DBITS).
module instr_mem_resp
    import instr_mem_resp_pkg::*;
#(
    parameter int unsigned       DBITS     = IMEM_DBITS,
    parameter int unsigned       ADDR_BITS = 10,
    parameter int unsigned       LATENCY   = 2,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [DBITS-1:0]  NOP_WORD  = IMEM_NOP_WORD
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [DBITS-1:0]     req_pc,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DBITS-1:0]     rsp_instr,
    output logic [DBITS-1:0]     rsp_pc,
    output logic                 rsp_err,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DBITS-1:0]     wr_data
`ifdef IMEM_PERF_EN
    ,
    output logic [31:0]          perf_req,
    output logic [31:0]          perf_stall,
    output logic [15:0]          perf_flush
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic [DBITS-1:0]     mem_q [2**ADDR_BITS];
    logic                 rdy_en_q;
    logic [OCC_W-1:0]     occ_q, occ_d;
    imem_entry_t          pipe_q [LATENCY];
    imem_entry_t          pipe_d [LATENCY];
    logic [LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
    logic                 accept_s;
    logic                 pop_s;
    logic                 req_err_s;
    logic [ADDR_BITS-1:0] rd_idx_s;
    logic [DBITS-1:0]     rd_word_s;
    imem_entry_t          new_entry_s;
    imem_entry_t          head_s;
    logic [OCC_W-1:0]     fifo_cnt_s;

    // occ counts pipeline plus buffer, so the buffer can never overflow.
    assign req_ready = rdy_en_q && !flush && (occ_q < OCC_W'(DEPTH));
    assign accept_s  = req_valid && req_ready;
    assign rsp_valid = (fifo_cnt_s != '0);
    assign pop_s     = rsp_valid && rsp_ready && !flush;
    assign rsp_instr = rsp_valid ? head_s.instr : '0;
    assign rsp_pc    = rsp_valid ? head_s.pc    : '0;
    assign rsp_err   = rsp_valid ? head_s.err   : 1'b0;

    // Address decode and read-first RAM lookup at the accept edge.
    always_comb begin
        rd_idx_s          = req_pc[ADDR_BITS+1:2];
        rd_word_s         = mem_q[rd_idx_s];
        req_err_s         = imem_pc_err(req_pc, ADDR_BITS, DBITS);
        new_entry_s.pc    = req_pc;
        new_entry_s.err   = req_err_s;
        if (req_err_s) begin
            new_entry_s.instr = NOP_WORD;
        end else begin
            new_entry_s.instr = rd_word_s;
        end
    end

    // Program-load write port; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Pipeline shift and occupancy next state.
    always_comb begin
        pipe_d     = pipe_q;
        pipe_vld_d = pipe_vld_q;
        occ_d      = occ_q;
        if (flush) begin
            pipe_vld_d = '0;
            occ_d      = '0;
        end else begin
            for (int k = 1; k < LATENCY; k++) begin
                pipe_d[k]     = pipe_q[k-1];
                pipe_vld_d[k] = pipe_vld_q[k-1];
            end
            pipe_vld_d[0] = accept_s;
            if (accept_s) begin
                pipe_d[0] = new_entry_s;
            end else begin
                pipe_d[0] = pipe_q[0];
            end
            case ({accept_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pipeline, occupancy and post-reset ready enable.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rdy_en_q   <= 1'b0;
            occ_q      <= '0;
            pipe_vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            rdy_en_q   <= 1'b1;
            occ_q      <= occ_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_q     <= pipe_d;
        end
    end

    instr_mem_resp_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(imem_entry_t))
    ) u_resp_fifo (
        .clk         (clk),
        .rst_n       (res),
        .flush_i     (flush),
        .push_i      (pipe_vld_q[LATENCY-1]),
        .push_data_i (pipe_q[LATENCY-1]),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_cnt_s)
    );

`ifdef IMEM_PERF_EN
    logic [31:0] perf_req_q;
    logic [31:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    // Free-running event counters; flush does not clear them.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            perf_req_q   <= 32'd0;
            perf_stall_q <= 32'd0;
            perf_flush_q <= 16'd0;
        end else begin
            if (accept_s) begin
                perf_req_q <= perf_req_q + 32'd1;
            end
            if (req_valid && !req_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
        end
    end

    assign perf_req   = perf_req_q;
    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_mem_resp.sv
// Self-checking bench for instr_mem_resp: directed scenarios plus random traffic against a queue model.
module tb_instr_mem_resp;

    localparam int DB  = 32;
    localparam int AB  = 10;
    localparam int LAT = 2;
    localparam int DEP = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          res;
    logic          req_valid;
    logic          req_ready;
    logic [DB-1:0] req_pc;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DB-1:0] rsp_instr;
    logic [DB-1:0] rsp_pc;
    logic          rsp_err;
    logic          flush;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [DB-1:0] wr_data;
`ifdef IMEM_PERF_EN
    logic [31:0]   perf_req;
    logic [31:0]   perf_stall;
    logic [15:0]   perf_flush;
`endif

    always #5 clk = ~clk;

    instr_mem_resp #(
        .DBITS(DB), .ADDR_BITS(AB), .LATENCY(LAT), .DEPTH(DEP), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .res(res),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_pc(rsp_pc), .rsp_err(rsp_err), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef IMEM_PERF_EN
        , .perf_req(perf_req), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
        int          avail;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [1024];
    int          edge_n;
    bit          started;
    int          checks;
    int          errors;
    logic [31:0] p_req, p_stall;
    logic [15:0] p_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return started && (q.size() < DEP) && !flush && (res === 1'b1);
    endfunction

    function automatic bit m_valid();
        if (q.size() == 0) return 1'b0;
        return q[0].avail <= edge_n;
    endfunction

    function automatic bit pc_bad(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc >= 32'd4096);
    endfunction

    task automatic check_outputs();
        chk("req_ready", {31'd0, req_ready}, {31'd0, m_ready()});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid()});
        if (m_valid()) begin
            chk("rsp_instr", rsp_instr, q[0].instr);
            chk("rsp_pc", rsp_pc, q[0].pc);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, q[0].err});
        end
    endtask

    // Reference behaviour at one rising edge, using the inputs held across it.
    task automatic model_edge();
        bit   rdy, vld;
        exp_t e;
        if (res === 1'b1) begin
            rdy = m_ready();
            vld = m_valid();
            edge_n++;
            if (req_valid && !rdy) p_stall++;
            if (flush) begin
                p_flush++;
                q.delete();
            end else begin
                if (vld && rsp_ready) void'(q.pop_front());
                if (req_valid && rdy) begin
                    e.pc    = req_pc;
                    e.err   = pc_bad(req_pc);
                    e.instr = e.err ? NOP : ref_mem[req_pc / 4];
                    e.avail = edge_n + LAT;
                    q.push_back(e);
                    p_req++;
                end
            end
            started = 1'b1;
        end
        if (wr_en) ref_mem[wr_addr] = wr_data;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic issue(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        bit          acc;
        checks = 0; errors = 0; edge_n = 0; started = 1'b0;
        p_req = 32'd0; p_stall = 32'd0; p_flush = 16'd0;
        res = 1'b0; req_valid = 1'b0; req_pc = 32'd0; rsp_ready = 1'b0;
        flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 32'd0;

        #2;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_pc", rsp_pc, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        cycle();
        cycle();
        res = 1'b1;
        cycle();
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Program load.
        wr_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            wr_addr = AB'(i);
            wr_data = $urandom;
            cycle();
        end
        wr_addr = 10'd16;
        wr_data = 32'hDEADBEEF;
        cycle();
        wr_en = 1'b0;

        // Minimum latency read.
        rsp_ready = 1'b1;
        issue(32'h40);
        cycle();
        cycle();
        chk("lat_valid", {31'd0, rsp_valid}, 32'd1);
        chk("lat_instr", rsp_instr, 32'hDEADBEEF);
        chk("lat_pc", rsp_pc, 32'h40);
        chk("lat_err", {31'd0, rsp_err}, 32'd0);
        cycle();

        // Backpressure fills all outstanding slots.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        pc = 32'h40;
        for (int i = 0; i < 8; i++) begin
            req_pc = pc;
            acc = m_ready();
            cycle();
            if (acc) pc += 32'd4;
        end
        chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
        chk("bp_head_pc", rsp_pc, 32'h40);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("bp_ready_back", {31'd0, req_ready}, 32'd1);

        // Misaligned and out-of-range PCs.
        req_valid = 1'b1; req_pc = 32'h42; cycle();
        req_pc = 32'h1000; cycle();
        req_valid = 1'b0;
        cycle();
        chk("err1_err", {31'd0, rsp_err}, 32'd1);
        chk("err1_instr", rsp_instr, NOP);
        chk("err1_pc", rsp_pc, 32'h42);
        cycle();
        chk("err2_err", {31'd0, rsp_err}, 32'd1);
        chk("err2_pc", rsp_pc, 32'h1000);
        cycle();

        // Flush with three entries outstanding.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc = 32'h44; cycle();
        req_pc = 32'h48; cycle();
        req_pc = 32'h4C; cycle();
        req_valid = 1'b0;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b1;
        issue(32'h80);
        chk("flush_no_stale", {31'd0, rsp_valid}, 32'd0);
        cycle();
        cycle();
        chk("flush_new_valid", {31'd0, rsp_valid}, 32'd1);
        chk("flush_new_pc", rsp_pc, 32'h80);
        cycle();

        // Read-first on a same-cycle write.
        wr_en = 1'b1; wr_addr = 10'd16; wr_data = 32'h12345678;
        issue(32'h40);
        wr_en = 1'b0;
        cycle();
        cycle();
        chk("coll_old", rsp_instr, 32'hDEADBEEF);
        issue(32'h40);
        cycle();
        cycle();
        chk("coll_new", rsp_instr, 32'h12345678);
        cycle();

        // Asynchronous reset with two entries in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc = 32'h40; cycle();
        req_pc = 32'h44; cycle();
        req_valid = 1'b0;
        cycle();
        chk("prerst_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        res = 1'b0;
        #1;
        q.delete(); started = 1'b0;
        p_req = 32'd0; p_stall = 32'd0; p_flush = 16'd0;
        chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        chk("arst_pc", rsp_pc, 32'd0);
        cycle();
        res = 1'b1;
`ifdef IMEM_PERF_EN
        chk("arst_perf_req", perf_req, 32'd0);
        chk("arst_perf_stall", perf_stall, 32'd0);
        chk("arst_perf_flush", {16'd0, perf_flush}, 32'd0);
`endif
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            req_valid = ($urandom_range(0, 9) < 7);
            if (r == 0)      req_pc = $urandom;
            else if (r == 1) req_pc = ($urandom_range(0, 63) << 2) | 32'd2;
            else if (r == 2) req_pc = $urandom_range(0, 1023) << 2;
            else             req_pc = $urandom_range(0, 63) << 2;
            rsp_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            wr_en     = ($urandom_range(0, 4) == 0);
            wr_addr   = AB'($urandom_range(0, 63));
            wr_data   = $urandom;
            cycle();
        end
        req_valid = 1'b0; flush = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("drain_empty", {31'd0, rsp_valid}, 32'd0);
`ifdef IMEM_PERF_EN
        chk("perf_req", perf_req, p_req);
        chk("perf_stall", perf_stall, p_stall);
        chk("perf_flush", {16'd0, perf_flush}, {16'd0, p_flush});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_resp.md
Name: instr_mem_resp

Overview:
- Instruction-memory responder: the far end of the fetch PC interface.
- Accepts fetch requests (PC) with a valid/ready handshake and reads a word-addressed instruction RAM.
- Returns instruction words in request order after a fixed pipeline latency, through a small response buffer.
- Supports a flush, used on branch redirect, and a write port for program load.

Parameters:
- DBITS, 32, instruction and PC width.
- ADDR_BITS, 10, word-address width; RAM holds 2^ADDR_BITS words.
- LATENCY, 2, cycles from request accept to the entry landing in the response buffer (1..4).
- DEPTH, 4, max outstanding entries (pipeline plus buffer); power of two, 2..16.
- NOP_WORD, 32'h0, instruction returned on error.

Ports:
- clk  in  1  clock.
- res  in  1  reset: asynchronous, active-low.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_pc  in  DBITS  byte PC of the request.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_instr  out  DBITS  instruction word.
- rsp_pc  out  DBITS  PC echoed from the request.
- rsp_err  out  1  misaligned or out-of-range PC.
- flush  in  1  discard all in-flight and buffered entries.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  ADDR_BITS  word address of the write.
- wr_data  in  DBITS  data for the write.

Behaviour:
- Reset (res=0, async): all pipeline valids, buffer pointers and the occupancy count are cleared. req_ready=0 while reset is held, and becomes 1 on the first clock after release. rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0. RAM contents are not reset. Reset mid-operation drops every entry.
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
- Ready rule: req_ready = !flush && (occ < DEPTH). occ is registered, so there is no combinational path from rsp_ready to req_ready.
- Occupancy: occ increments on accept and decrements on pop. Accept and pop in the same cycle leave occ unchanged.
- Address decode:
  - Word index = req_pc[ADDR_BITS+1:2].
  - err = (req_pc[1:0] != 0) || (req_pc[DBITS-1:ADDR_BITS+2] != 0).
  - On err, the RAM result is replaced by NOP_WORD.
- Latency:
  - An entry accepted at edge N is written into the buffer at edge N+LATENCY.
  - rsp_valid is asserted from that cycle.
  - Minimum request-to-response latency is LATENCY cycles.
  - Responses are strictly in request order.
- Pop: a response is popped when rsp_valid && rsp_ready. rsp_* are driven from the buffer head and are stable while rsp_valid && !rsp_ready.
- Buffer: DEPTH entries with wrapping pointers. Because of the occupancy limit it never overflows; there is no backpressure into the pipeline.
- Flush (synchronous, priority over everything except reset):
  - Clears pipeline valids, buffer pointers and occ at the edge.
  - A pop or accept in the same cycle is void.
  - rsp_valid=0 in the next cycle.
- RAM: one read port, one write port. Read-first on collision: a read and a write to the same word in the same cycle returns the old data. A write never affects an entry already past its read stage.
- With flush=0, every accepted request produces exactly one response.

Optional Feature:
- Macro IMEM_PERF_EN.
- Defined:
  - Adds outputs perf_req (32 bits, accepted requests), perf_stall (32 bits, cycles with req_valid && !req_ready) and perf_flush (16 bits, flush count).
  - Async-reset to 0; wrap modulo 2^width; not cleared by flush.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the NOP_WORD default;
  - the function deriving the error condition from PC, ADDR_BITS and DBITS;
  - the response-entry struct {instr, pc, err}.
- One sub-module: resp_fifo (parameterised DEPTH/width, push/pop/flush, count output) used as the response buffer.

Test Plan:
- Reset, then back-to-back reads: RAM[16]=32'hDEADBEEF. Request PC 32'h40 at cycle 0 with rsp_ready=1 -> rsp_valid at cycle 2 with rsp_instr=DEADBEEF, rsp_pc=32'h40, rsp_err=0.
- Backpressure: rsp_ready=0, req_valid held, PCs 0x40, 0x44, 0x48 and so on -> exactly 4 accepted, then req_ready=0. Release rsp_ready -> 4 responses in order, then req_ready returns.
- Errors: PC 32'h42 and PC 32'h1000 (ADDR_BITS=10) -> rsp_err=1, rsp_instr=NOP_WORD, rsp_pc echoed.
- Flush: 3 requests outstanding, flush pulsed for 1 cycle -> rsp_valid=0 the next cycle and no stale response. A new request to 0x80 returns after 2 cycles.
- Write collision: wr_en to word 16 with 32'h12345678 in the same cycle as a read of PC 0x40 -> old data returned. The next read of 0x40 returns 12345678.
- Async reset mid-stream with 2 entries in flight -> rsp_valid=0 immediately. After release, no stale response and perf counters (if enabled) read 0.
